// File: rtl/dpb_axi_burst_write_master_pkg.sv
// Shared AXI encodings, DPB layout defaults and helpers for the DPB write master.
// Error address capture is enabled with DPB_WR_ERR_CAPTURE_EN.
package dpb_axi_burst_write_master_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic       AXI_LOCK_NORMAL    = 1'b0;
    localparam logic [3:0] AXI_CACHE_BUF_MOD  = 4'b0011;
    localparam logic [2:0] AXI_PROT_DATA_SEC  = 3'b000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        AX_SIZE_1   = 3'd0,
        AX_SIZE_2   = 3'd1,
        AX_SIZE_4   = 3'd2,
        AX_SIZE_8   = 3'd3,
        AX_SIZE_16  = 3'd4,
        AX_SIZE_32  = 3'd5,
        AX_SIZE_64  = 3'd6,
        AX_SIZE_128 = 3'd7
    } ax_size_e;

    localparam int DPB_IU_OFFSET     = 49152;
    localparam int DPB_BU_ROW_OFFSET = 1536;
    localparam int DPB_BU_OFFSET     = 192;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wr_state_e;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpb_wr_addr_queue.sv
// Small synchronous FIFO holding awaddr of bursts still waiting for a B response.
// Only instantiated when DPB_WR_ERR_CAPTURE_EN is defined.
module dpb_wr_addr_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wrap_inc(wr_q);
            if (do_pop) rd_q <= wrap_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/dpb_axi_burst_write_master.sv
// Drains 8x8 pixel blocks from the SAO output FIFO into the DPB as AXI4 INCR bursts.
// Optional first-error address capture: define DPB_WR_ERR_CAPTURE_EN.
module dpb_axi_burst_write_master
    import dpb_axi_burst_write_master_pkg::*;
#(
    parameter int AXI_ADDR_W       = 32,
    parameter int AXI_DATA_W       = 512,
    parameter int BEATS            = 3,
    parameter int BLK_COORD_W      = 10,
    parameter int LOG2_BLK_PER_CTU = 3,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int IU_OFFSET        = DPB_IU_OFFSET,
    parameter int BU_ROW_OFFSET    = DPB_BU_ROW_OFFSET,
    parameter int BU_OFFSET        = DPB_BU_OFFSET
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      fifo_is_empty_in,
    output logic                                      fifo_rd_en_out,
    input  logic [2*BLK_COORD_W+BEATS*AXI_DATA_W-1:0] fifo_data_in,
    input  logic [AXI_ADDR_W-1:0]                     dpb_axi_addr_in,
    input  logic [AXI_ADDR_W-1:0]                     iu_row_offset_in,
    output logic                                      axi_awid,
    output logic [AXI_ADDR_W-1:0]                     axi_awaddr,
    output logic [7:0]                                axi_awlen,
    output logic [2:0]                                axi_awsize,
    output logic [1:0]                                axi_awburst,
    output logic                                      axi_awlock,
    output logic [3:0]                                axi_awcache,
    output logic [2:0]                                axi_awprot,
    output logic                                      axi_awvalid,
    input  logic                                      axi_awready,
    output logic [AXI_DATA_W-1:0]                     axi_wdata,
    output logic [AXI_DATA_W/8-1:0]                   axi_wstrb,
    output logic                                      axi_wlast,
    output logic                                      axi_wvalid,
    input  logic                                      axi_wready,
    input  logic                                      axi_bid,
    input  logic [1:0]                                axi_bresp,
    input  logic                                      axi_bvalid,
    output logic                                      axi_bready,
    output logic                                      idle_out,
    output logic [7:0]                                err_count_out,
    input  logic                                      err_clr_in,
    output logic                                      err_valid_out,
    output logic [AXI_ADDR_W-1:0]                     err_addr_out
);

    localparam int A     = AXI_ADDR_W;
    localparam int DW    = AXI_DATA_W;
    localparam int PAY_W = BEATS * AXI_DATA_W;
    localparam int CNT_W = 4;
    localparam int BT_W  = 5;
    localparam int L     = LOG2_BLK_PER_CTU;

    logic [BLK_COORD_W-1:0] x_blk;
    logic [BLK_COORD_W-1:0] y_blk;
    logic [PAY_W-1:0]       payload;

    wr_state_e        state_q;
    wr_state_e        state_d;
    logic [PAY_W-1:0] rest_q;
    logic [BT_W-1:0]  beat_q;
    logic [CNT_W-1:0] outst_q;
    logic [A-1:0]     frame_base_q;
    logic [7:0]       err_cnt_q;

    logic         pop;
    logic         origin;
    logic [A-1:0] base;
    logic [A-1:0] blk_addr;
    logic         aw_hs;
    logic         w_hs;
    logic         b_hs;
    logic         err_hit;
    logic         burst_done;

    assign {x_blk, y_blk, payload} = fifo_data_in;

    assign axi_awid    = 1'b0;
    assign axi_awlen   = 8'(BEATS - 1);
    assign axi_awsize  = 3'(log2(AXI_DATA_W / 8));
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_awlock  = AXI_LOCK_NORMAL;
    assign axi_awcache = AXI_CACHE_BUF_MOD;
    assign axi_awprot  = AXI_PROT_DATA_SEC;
    assign axi_wstrb   = '1;
    assign axi_bready  = 1'b1;

    assign pop = (state_q == ST_IDLE) && !fifo_is_empty_in
              && (outst_q < CNT_W'(MAX_OUTSTANDING));
    assign fifo_rd_en_out = pop;

    assign aw_hs   = axi_awvalid && axi_awready;
    assign w_hs    = axi_wvalid && axi_wready;
    assign b_hs    = axi_bvalid;
    assign err_hit = b_hs && (axi_bresp[1] || axi_bid);

    // AW and W finish independently; leave BURST once both are settled.
    assign burst_done = (state_q == ST_BURST)
                     && (!axi_awvalid || axi_awready)
                     && (!axi_wvalid || (axi_wready && axi_wlast));

    always_comb begin
        origin   = (x_blk == '0) && (y_blk == '0);
        base     = origin ? dpb_axi_addr_in : frame_base_q;
        blk_addr = base
                 + A'(y_blk >> L) * iu_row_offset_in
                 + A'(x_blk >> L) * A'(IU_OFFSET)
                 + A'(y_blk[L-1:0]) * A'(BU_ROW_OFFSET)
                 + A'(x_blk[L-1:0]) * A'(BU_OFFSET);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pop) state_d = ST_BURST;
            ST_BURST: if (burst_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            axi_awvalid  <= 1'b0;
            axi_awaddr   <= '0;
            axi_wvalid   <= 1'b0;
            axi_wlast    <= 1'b0;
            axi_wdata    <= '0;
            rest_q       <= '0;
            beat_q       <= '0;
            frame_base_q <= '0;
        end else if (pop) begin
            axi_awvalid <= 1'b1;
            axi_awaddr  <= blk_addr;
            axi_wvalid  <= 1'b1;
            axi_wlast   <= (BEATS == 1);
            axi_wdata   <= payload[DW-1:0];
            rest_q      <= payload >> DW;
            beat_q      <= '0;
            if (origin) frame_base_q <= dpb_axi_addr_in;
        end else begin
            if (aw_hs) axi_awvalid <= 1'b0;
            if (w_hs) begin
                if (axi_wlast) begin
                    axi_wvalid <= 1'b0;
                    axi_wlast  <= 1'b0;
                end else begin
                    axi_wdata <= rest_q[DW-1:0];
                    rest_q    <= rest_q >> DW;
                    beat_q    <= beat_q + 1'b1;
                    axi_wlast <= (beat_q == BT_W'(BEATS - 2));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outst_q <= '0;
        end else begin
            case ({aw_hs, b_hs && (outst_q != '0)})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else if (err_clr_in) begin
            err_cnt_q <= '0;
        end else if (err_hit && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_count_out = err_cnt_q;
    assign idle_out      = (state_q == ST_IDLE) && (outst_q == '0);

`ifdef DPB_WR_ERR_CAPTURE_EN
    logic [A-1:0]     q_head;
    logic [CNT_W-1:0] q_count;
    logic             err_valid_q;
    logic [A-1:0]     err_addr_q;

    dpb_wr_addr_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (A),
        .CNT_W (CNT_W)
    ) u_addr_queue (
        .clk   (clk),
        .reset (reset),
        .push  (aw_hs),
        .pop   (b_hs && (q_count != '0)),
        .din   (axi_awaddr),
        .head  (q_head),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_clr_in) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_hit && !err_valid_q) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= q_head;
        end
    end

    assign err_valid_out = err_valid_q;
    assign err_addr_out  = err_addr_q;
`else
    assign err_valid_out = 1'b0;
    assign err_addr_out  = '0;
`endif

endmodule

// File: doc/dpb_axi_burst_write_master.md
Name: dpb_axi_burst_write_master

Overview:
Drains deblocked/SAO-filtered 8x8 pixel blocks from the output FIFO and writes each one to the decoded picture buffer (DPB) as one AXI4 INCR burst. It is the parametrised successor of the single-outstanding DPB write master. It adds the following over that block:
- configurable data width, beats per block and block-coordinate widths;
- concurrent AW/W issue;
- up to MAX_OUTSTANDING bursts awaiting a B response;
- a run-time CTU row pitch;
- response error accounting.

It sits between the SAO output FIFO and the DDR AXI interconnect port.

Parameters:
- AXI_ADDR_W, 32, AXI address width.
- AXI_DATA_W, 512, W data width; must be a power of 2 and at least 8.
- BEATS, 3, beats per block burst (1..16); awlen = BEATS-1.
- BLK_COORD_W, 10, width of the x and y block coordinates (8x8 units).
- LOG2_BLK_PER_CTU, 3, log2 of blocks per CTU edge.
- MAX_OUTSTANDING, 4, maximum accepted AW without a B response (1..15).
- IU_OFFSET, 49152, byte offset between horizontally adjacent CTUs.
- BU_ROW_OFFSET, 1536, byte offset between block rows inside a CTU.
- BU_OFFSET, 192, byte offset between adjacent blocks inside a CTU.

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset: one clock; reset is asynchronous and active-low.
- fifo_is_empty_in, in, 1, source FIFO empty flag (show-ahead FIFO).
- fifo_rd_en_out, out, 1, pop strobe for the source FIFO.
- fifo_data_in, in, 2*BLK_COORD_W+BEATS*AXI_DATA_W, packed as {x_blk, y_blk, payload}; beat k = payload[k*AXI_DATA_W +: AXI_DATA_W].
- dpb_axi_addr_in, in, AXI_ADDR_W, base address of the current picture.
- iu_row_offset_in, in, AXI_ADDR_W, byte offset between CTU rows; must be stable during a picture.
- AW channel:
  - axi_awid, out, 1.
  - axi_awaddr, out, AXI_ADDR_W.
  - axi_awlen, out, 8.
  - axi_awsize, out, 3.
  - axi_awburst, out, 2.
  - axi_awlock, out, 1.
  - axi_awcache, out, 4.
  - axi_awprot, out, 3.
  - axi_awvalid, out, 1.
  - axi_awready, in, 1.
- W channel:
  - axi_wdata, out, AXI_DATA_W.
  - axi_wstrb, out, AXI_DATA_W/8.
  - axi_wlast, out, 1.
  - axi_wvalid, out, 1.
  - axi_wready, in, 1.
- B channel:
  - axi_bid, in, 1.
  - axi_bresp, in, 2.
  - axi_bvalid, in, 1.
  - axi_bready, out, 1.
- idle_out, out, 1, no burst in flight and none outstanding.
- err_count_out, out, 8, saturating count of non-OKAY responses.
- err_clr_in, in, 1, clears the error count and error capture.
- err_valid_out, out, 1, error address captured (optional feature).
- err_addr_out, out, AXI_ADDR_W, awaddr of the first failed burst (optional feature).

Behaviour:
- Constant AW outputs:
  - awid = 0, awlen = BEATS-1, awsize = log2(AXI_DATA_W/8), awburst = INCR.
  - awlock = 0, awcache = 4'b0011, awprot = 3'b000.
  - wstrb is all ones.
  - bready is tied to 1.
- Reset values (reset low, asynchronous):
  - state = IDLE.
  - awvalid, wvalid, wlast = 0.
  - awaddr, wdata = 0.
  - outstanding count = 0, beat counter = 0.
  - err_count = 0, err_valid = 0, err_addr = 0, frame-base register = 0.
- State IDLE:
  - fifo_rd_en_out = !fifo_is_empty_in && (outstanding < MAX_OUTSTANDING). This is combinational and asserted only in IDLE.
  - On pop, register the payload and compute awaddr:
    base + y_ctu*iu_row_offset_in + x_ctu*IU_OFFSET + y_in*BU_ROW_OFFSET + x_in*BU_OFFSET
    - x_ctu/y_ctu = coordinate >> LOG2_BLK_PER_CTU.
    - x_in/y_in = the low LOG2_BLK_PER_CTU bits of the coordinate.
    - Arithmetic is truncated to AXI_ADDR_W bits.
  - base is dpb_axi_addr_in when the popped block is (0,0); that value is also latched into the frame-base register. Otherwise base is the frame-base register.
  - The next state is BURST. On the next cycle awvalid = 1, wvalid = 1, wdata = beat 0, and wlast = (BEATS == 1).
- State BURST:
  - AW and W run independently.
  - awvalid drops after the cycle in which awready is high.
  - Each wready high while wvalid is high advances the beat: wdata = next beat; wlast is high on beat BEATS-1.
  - wvalid drops after the last-beat handshake.
  - Return to IDLE when both AW and the final W handshake are done; they may complete in the same cycle or in either order.
  - The first possible next pop is the cycle after that return, giving a minimum of BEATS+1 cycles per block at zero backpressure.
  - No further pop occurs while in BURST.
- Outstanding counter:
  - +1 on an AW handshake, -1 on a B handshake; unchanged when both happen in the same cycle.
  - It never exceeds MAX_OUTSTANDING because popping is gated on it.
- Error accounting:
  - A B handshake with bresp[1] = 1 or bid != 0 increments err_count, saturating at 255.
  - err_clr_in clears err_count. If it coincides with a new error, the clear wins.
  - Failed bursts are not retried.
- idle_out = (state == IDLE) && (outstanding == 0).
- Reset mid-burst abandons the burst. The popped block is lost; the upstream FIFO is reset by the same reset.

Optional Feature:
Macro DPB_WR_ERR_CAPTURE_EN.
- Defined:
  - A MAX_OUTSTANDING-deep address queue pushes awaddr on each AW handshake and pops on each B handshake.
  - On the first erroneous B response while err_valid_out = 0, err_addr_out is set to the head address and err_valid_out to 1. Both are sticky until err_clr_in.
- Undefined:
  - No queue is built.
  - err_valid_out and err_addr_out are tied to 0.

Decomposition:
- Shared package / define file:
  - AXI burst, lock, cache, prot and response encodings.
  - AX_SIZE encodings.
  - A log2 function.
  - DPB layout offset defaults: IU_OFFSET, BU_ROW_OFFSET, BU_OFFSET.
- Sub-module dpb_wr_addr_queue: a small synchronous FIFO (push, pop, head, count) used for error capture. It is instantiated only under the macro.

Test Plan:
1. Zero backpressure, BEATS=3: one block (0,0) with base 0x1000_0000 → awaddr 0x1000_0000, awlen=2, three W beats with wlast on the third, idle_out high after B.
2. Block x=9, y=10, iu_row_offset_in=0x60000 → awaddr = base + 1*0x60000 + 1*49152 + 2*1536 + 1*192 = base + 0x6CCC0.
3. awready delayed 5 cycles while wready=1 → all W beats complete first, and the state returns to IDLE only after the AW handshake. The reverse ordering behaves the same way.
4. bvalid withheld, MAX_OUTSTANDING=4, 6 blocks queued → exactly 4 pops, fifo_rd_en_out low until the first B, then the remainder drains.
5. bresp=2'b10 on the second of three bursts → err_count=1. With the macro, err_addr_out = second awaddr and err_valid_out=1; both clear on err_clr_in.
6. reset asserted low mid-burst (beat 1 of 3) → all outputs return to reset values immediately; a new block after release is written correctly.
